// File: rtl/countdown_timer.sv
// Loadable mm:ss countdown timer with a one-cycle done pulse; all outputs registered; tick/start/pause are strobes, no backpressure.
// Optional build macro COUNTDOWN_AUTORELOAD_EN restarts from the reload register on expiry instead of stopping in EXPIRED.
module countdown_timer #(
  parameter int unsigned MAX_MIN = 59,
  parameter int unsigned MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_e;

  localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
  localparam logic [5:0] MAX_SEC_V = 6'(MAX_SEC);

  state_e     state_q, state_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [5:0] rl_min_q, rl_min_d, rl_sec_q, rl_sec_d;
  logic       done_q, done_d;
  logic [5:0] ld_min_c, ld_sec_c;
  logic       cnt_nz, rl_nz, last_step;

  assign ld_min_c  = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
  assign ld_sec_c  = (load_sec > MAX_SEC_V) ? MAX_SEC_V : load_sec;
  assign cnt_nz    = (min_q != 6'd0) || (sec_q != 6'd0);
  assign rl_nz     = (rl_min_q != 6'd0) || (rl_sec_q != 6'd0);
  assign last_step = (min_q == 6'd0) && (sec_q == 6'd1);

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    rl_min_d = rl_min_q;
    rl_sec_d = rl_sec_q;
    done_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      min_d   = 6'd0;
      sec_d   = 6'd0;
    end else if (load && (state_q != RUN)) begin
      state_d  = IDLE;
      min_d    = ld_min_c;
      sec_d    = ld_sec_c;
      rl_min_d = ld_min_c;
      rl_sec_d = ld_sec_c;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = cnt_nz ? RUN : EXPIRED;
            done_d  = !cnt_nz;
          end
        end
        RUN: begin
          // pause outranks tick, so a coincident tick is dropped
          if (pause) begin
            state_d = PAUSED;
          end else if (tick && cnt_nz) begin
            if (last_step) begin
              min_d  = 6'd0;
              sec_d  = 6'd0;
              done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (rl_nz) begin
                min_d = rl_min_q;
                sec_d = rl_sec_q;
              end else begin
                state_d = EXPIRED;
              end
`else
              state_d = EXPIRED;
`endif
            end else if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
            end else begin
              min_d = min_q - 6'd1;
              sec_d = MAX_SEC_V;
            end
          end
        end
        PAUSED: begin
          if (start) state_d = RUN;
        end
        EXPIRED: begin
          if (start) begin
            min_d   = rl_min_q;
            sec_d   = rl_sec_q;
            state_d = rl_nz ? RUN : EXPIRED;
            done_d  = !rl_nz;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      rl_min_q <= 6'd0;
      rl_sec_q <= 6'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      rl_min_q <= rl_min_d;
      rl_sec_q <= rl_sec_d;
      done_q   <= done_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random control traffic against a total-seconds reference model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, load, start, pause, clear;
  logic [5:0] load_min, load_sec;
  logic [5:0] minutes, seconds;
  logic       running, expired, done;

  int checks = 0;
  int failures = 0;

  // Reference model: count kept as total seconds, mode as a small integer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
  int m_total, m_rl, m_mode;
  bit m_done;

  countdown_timer #(.MAX_MIN(59), .MAX_SEC(59)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start),
    .pause(pause), .clear(clear), .minutes(minutes), .seconds(seconds),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_total = 0; m_rl = 0; m_mode = M_IDLE; m_done = 0;
  endtask

  task automatic model_step();
    bit nd = 0;
    if (clear) begin
      m_mode = M_IDLE; m_total = 0;
    end else if (load && m_mode != M_RUN) begin
      m_total = clampv(int'(load_min), 59) * 60 + clampv(int'(load_sec), 59);
      m_rl = m_total; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          if (m_total > 0) m_mode = M_RUN;
          else begin m_mode = M_EXP; nd = 1; end
        end
        M_RUN: if (pause) m_mode = M_PAUSED;
          else if (tick && m_total > 0) begin
            m_total--;
            if (m_total == 0) begin
              nd = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (m_rl > 0) m_total = m_rl;
              else m_mode = M_EXP;
`else
              m_mode = M_EXP;
`endif
            end
          end
        M_PAUSED: if (start) m_mode = M_RUN;
        default: if (start) begin
          m_total = m_rl;
          if (m_rl > 0) m_mode = M_RUN;
          else nd = 1;
        end
      endcase
    end
    m_done = nd;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".min"}, minutes, m_total / 60);
    check_eq({tag, ".sec"}, seconds, m_total % 60);
    check_eq({tag, ".running"}, running, (m_mode == M_RUN) ? 1 : 0);
    check_eq({tag, ".expired"}, expired, (m_mode == M_EXP) ? 1 : 0);
    check_eq({tag, ".done"}, done, m_done ? 1 : 0);
  endtask

  // Called at a negedge: apply inputs for one edge, update model, compare at next negedge.
  task automatic step(input string tag, input bit t, input bit ld, input int lm, input int ls,
                      input bit st, input bit pa, input bit cl);
    tick = t; load = ld; load_min = 6'(lm); load_sec = 6'(ls);
    start = st; pause = pa; clear = cl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
    tick = 0; load = 0; start = 0; pause = 0; clear = 0;
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; tick = 0; load = 0; start = 0; pause = 0; clear = 0;
    load_min = 0; load_sec = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    reset = 0;
    step("idle", 0, 0, 0, 0, 0, 0, 0);

    // 01:02 down to expiry
    step("load102", 0, 1, 1, 2, 0, 0, 0);
    step("start102", 0, 0, 0, 0, 1, 0, 0);
    ticks("run102", 62);
    step("after102", 0, 0, 0, 0, 0, 0, 0);

    // pause with coincident tick
    step("load003", 0, 1, 0, 3, 0, 0, 0);
    step("start003", 0, 0, 0, 0, 1, 0, 0);
    step("tick003", 1, 0, 0, 0, 0, 0, 0);
    step("pausetick", 1, 0, 0, 0, 0, 1, 0);
    ticks("paused", 5);
    step("resume", 0, 0, 0, 0, 1, 0, 0);
    ticks("run003", 2);
    step("after003", 0, 0, 0, 0, 0, 0, 0);

    // clamping
    step("clamp", 0, 1, 63, 60, 0, 0, 0);
    check_eq("clamp.min_abs", minutes, 59);
    check_eq("clamp.sec_abs", seconds, 59);
    step("startclamp", 0, 0, 0, 0, 1, 0, 0);
    ticks("runclamp", 1);

    // start at 00:00
    step("clr0", 0, 0, 0, 0, 0, 0, 1);
    step("start0", 0, 0, 0, 0, 1, 0, 0);
    ticks("exp_ticks", 10);

    // load ignored in RUN, then clear, then zero start
    step("load007", 0, 1, 0, 7, 0, 0, 0);
    step("start007", 0, 0, 0, 0, 1, 0, 0);
    ticks("run007", 2);
    step("loadinrun", 1, 1, 0, 9, 0, 0, 0);
    step("clearrun", 0, 0, 0, 0, 0, 0, 1);
    step("startcleared", 0, 0, 0, 0, 1, 0, 0);
    step("aftercleared", 0, 0, 0, 0, 0, 0, 0);

    // async reset while running at 00:30
    step("load040", 0, 1, 0, 40, 0, 0, 0);
    step("start040", 0, 0, 0, 0, 1, 0, 0);
    ticks("run040", 10);
    #2 reset = 1;
    #1;
    check_eq("arst.min", minutes, 0);
    check_eq("arst.sec", seconds, 0);
    check_eq("arst.running", running, 0);
    check_eq("arst.done", done, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    compare_all("postarst");

`ifdef COUNTDOWN_AUTORELOAD_EN
    step("arload", 0, 1, 0, 2, 0, 0, 0);
    step("arstart", 0, 0, 0, 0, 1, 0, 0);
    ticks("arrun", 2);
    check_eq("ar.sec_abs", seconds, 2);
    check_eq("ar.running_abs", running, 1);
    check_eq("ar.done_abs", done, 1);
    ticks("arrun2", 3);
`endif

    // random control traffic
    for (int i = 0; i < 3000; i++) begin
      bit t, ld, st, pa, cl;
      int lm, ls;
      cl = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 7) == 0);
      pa = ($urandom_range(0, 15) == 0);
      t  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        lm = $urandom_range(0, 63); ls = $urandom_range(0, 63);
      end else begin
        lm = 0; ls = $urandom_range(0, 4);
      end
      step("rand", t, ld, lm, ls, st, pa, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
